// File: rtl/vending_pkg.sv
// Shared vending controller types: FSM state encoding and one-hot push status codes.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_REFUND   = 2'd3
  } state_t;

  localparam logic [3:0] PUSH_IDLE       = 4'b1000;
  localparam logic [3:0] PUSH_ITEM_SEL   = 4'b0100;
  localparam logic [3:0] PUSH_DISPENSE   = 4'b0010;
  localparam logic [3:0] PUSH_REFUND_SIG = 4'b0001;

endpackage

// File: rtl/vend_timeout_timer.sv
// Idle-cycle timer: counts enabled cycles without a clear and emits a one-cycle
// registered expire pulse so the consumer acts on the TIMEOUT_CYC-th idle cycle.
module vend_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYC - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_expire;

  // Expire is registered one cycle early so it lines up with the final idle cycle.
  always_ff @(posedge clk) begin
    if (reset || !en || clr) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= (r_cnt == CNT_FIRE);
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expire = r_expire;

endmodule

// File: rtl/vending_multi_ctrl.sv
// Multi-item vending controller: saturating credit, per-item price/stock checks,
// dispense and change over valid/ready. Define VEND_MULTI_VEND_EN to keep leftover
// credit in CREDIT after a dispense instead of returning change immediately.
module vending_multi_ctrl
  import vending_pkg::*;
#(
  parameter  int unsigned N_ITEMS     = 4,
  parameter  int unsigned AMT_W       = 8,
  parameter  int unsigned TIMEOUT_CYC = 1000,
  localparam int unsigned IDX_W       = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coin_in,
  input  logic [AMT_W-1:0]         coin_value,
  input  logic [N_ITEMS*AMT_W-1:0] price,
  input  logic [N_ITEMS-1:0]       stock_empty,
  input  logic                     sel_valid,
  input  logic [IDX_W-1:0]         sel_item,
  input  logic                     cancel,
  output logic                     dispense_valid,
  output logic [IDX_W-1:0]         dispense_item,
  input  logic                     dispense_ready,
  output logic                     refund_valid,
  output logic [AMT_W-1:0]         refund_amt,
  input  logic                     refund_ready,
  output logic [AMT_W-1:0]         credit,
  output logic [3:0]               push,
  output logic                     coin_reject,
  output logic                     sel_err
);

  state_t           r_state;
  logic [AMT_W-1:0] r_credit;
  logic             r_dispense_valid;
  logic [IDX_W-1:0] r_dispense_item;
  logic             r_refund_valid;
  logic [AMT_W-1:0] r_refund_amt;
  logic [3:0]       r_push;
  logic             r_coin_reject;
  logic             r_sel_err;

  logic             w_expire;
  logic             w_sel_ok;
  logic [AMT_W-1:0] w_sel_price;
  logic [AMT_W:0]   w_sum;
  logic             w_coin_ovf;
  logic [AMT_W-1:0] w_credit_coin;
  logic             w_timeout;

  vend_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (coin_in | sel_valid),
    .en     (r_state == ST_CREDIT),
    .expire (w_expire)
  );

  // Out-of-range indices never match, so they fall out as refused selections.
  always_comb begin
    w_sel_ok    = 1'b0;
    w_sel_price = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel_item == IDX_W'(i)) begin
        w_sel_price = price[i*AMT_W +: AMT_W];
        w_sel_ok    = !stock_empty[i] && (r_credit >= price[i*AMT_W +: AMT_W]);
      end
    end
  end

  assign w_sum         = {1'b0, r_credit} + {1'b0, coin_value};
  assign w_coin_ovf    = w_sum[AMT_W];
  assign w_credit_coin = (coin_in && !w_coin_ovf) ? w_sum[AMT_W-1:0] : r_credit;
  assign w_timeout     = w_expire && !coin_in && !sel_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_credit         <= '0;
      r_dispense_valid <= 1'b0;
      r_dispense_item  <= '0;
      r_refund_valid   <= 1'b0;
      r_refund_amt     <= '0;
      r_push           <= PUSH_IDLE;
      r_coin_reject    <= 1'b0;
      r_sel_err        <= 1'b0;
    end else begin
      r_coin_reject <= 1'b0;
      r_sel_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (coin_in) begin
            r_credit <= coin_value;
            r_state  <= ST_CREDIT;
            r_push   <= PUSH_ITEM_SEL;
          end
        end
        ST_CREDIT: begin
          if (cancel || (!sel_valid && w_timeout)) begin
            r_coin_reject <= coin_in;
            if (r_credit != '0) begin
              r_state        <= ST_REFUND;
              r_push         <= PUSH_REFUND_SIG;
              r_refund_valid <= 1'b1;
              r_refund_amt   <= r_credit;
            end else begin
              r_state <= ST_IDLE;
              r_push  <= PUSH_IDLE;
            end
          end else if (sel_valid && w_sel_ok) begin
            r_coin_reject    <= coin_in;
            r_credit         <= r_credit - w_sel_price;
            r_dispense_item  <= sel_item;
            r_dispense_valid <= 1'b1;
            r_state          <= ST_DISPENSE;
            r_push           <= PUSH_DISPENSE;
          end else begin
            r_credit      <= w_credit_coin;
            r_coin_reject <= coin_in && w_coin_ovf;
            r_sel_err     <= sel_valid;
          end
        end
        ST_DISPENSE: begin
          r_coin_reject <= coin_in;
          if (dispense_ready) begin
            r_dispense_valid <= 1'b0;
            if (r_credit != '0) begin
`ifdef VEND_MULTI_VEND_EN
              r_state <= ST_CREDIT;
              r_push  <= PUSH_ITEM_SEL;
`else
              r_state        <= ST_REFUND;
              r_push         <= PUSH_REFUND_SIG;
              r_refund_valid <= 1'b1;
              r_refund_amt   <= r_credit;
`endif
            end else begin
              r_state <= ST_IDLE;
              r_push  <= PUSH_IDLE;
            end
          end
        end
        ST_REFUND: begin
          r_coin_reject <= coin_in;
          if (refund_ready) begin
            r_refund_valid <= 1'b0;
            r_refund_amt   <= '0;
            r_credit       <= '0;
            r_state        <= ST_IDLE;
            r_push         <= PUSH_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_push  <= PUSH_IDLE;
        end
      endcase
    end
  end

  assign dispense_valid = r_dispense_valid;
  assign dispense_item  = r_dispense_item;
  assign refund_valid   = r_refund_valid;
  assign refund_amt     = r_refund_amt;
  assign credit         = r_credit;
  assign push           = r_push;
  assign coin_reject    = r_coin_reject;
  assign sel_err        = r_sel_err;

endmodule

// File: tb/tb_vending_multi_ctrl.sv
// Self-checking bench for vending_multi_ctrl: directed scenarios plus randomized
// transactions against an arithmetic credit model. Honors VEND_MULTI_VEND_EN.
module tb_vending_multi_ctrl;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int TO = 1000;
  localparam logic [3:0] P_IDLE = 4'b1000, P_CREDIT = 4'b0100,
                         P_DISP = 4'b0010, P_REF = 4'b0001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          coin_in = 1'b0;
  logic [AW-1:0] coin_value = '0;
  logic [N*AW-1:0] price = '0;
  logic [N-1:0]  stock_empty = '0;
  logic          sel_valid = 1'b0;
  logic [1:0]    sel_item = '0;
  logic          cancel = 1'b0;
  logic          dispense_valid;
  logic [1:0]    dispense_item;
  logic          dispense_ready = 1'b0;
  logic          refund_valid;
  logic [AW-1:0] refund_amt;
  logic          refund_ready = 1'b0;
  logic [AW-1:0] credit;
  logic [3:0]    push;
  logic          coin_reject;
  logic          sel_err;

  int errors = 0;
  int checks = 0;
  int pr[N];

  vending_multi_ctrl #(.N_ITEMS(N), .AMT_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .coin_in(coin_in), .coin_value(coin_value),
    .price(price), .stock_empty(stock_empty), .sel_valid(sel_valid),
    .sel_item(sel_item), .cancel(cancel), .dispense_valid(dispense_valid),
    .dispense_item(dispense_item), .dispense_ready(dispense_ready),
    .refund_valid(refund_valid), .refund_amt(refund_amt),
    .refund_ready(refund_ready), .credit(credit), .push(push),
    .coin_reject(coin_reject), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_prices();
    for (int i = 0; i < N; i++) price[i*AW +: AW] = AW'(pr[i]);
  endtask

  task automatic pulse_coin(input int v);
    coin_in = 1'b1; coin_value = AW'(v);
    tick();
    coin_in = 1'b0;
  endtask

  task automatic pulse_sel(input int it);
    sel_valid = 1'b1; sel_item = 2'(it);
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  function automatic logic [3:0] push_for(input int outcome);
    case (outcome)
      0: return P_CREDIT;
      1: return P_DISP;
      2: return P_REF;
      default: return P_IDLE;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (push !== P_IDLE) begin errors++; $display("FAIL reset_push: got %b want %b", push, P_IDLE); end
    checks++; if (credit !== 0) begin errors++; $display("FAIL reset_credit: got %0d want 0", credit); end
    checks++; if (dispense_valid !== 1'b0 || dispense_item !== 2'd0) begin errors++; $display("FAIL reset_dispense: got v=%b i=%0d want 0/0", dispense_valid, dispense_item); end
    checks++; if (refund_valid !== 1'b0 || refund_amt !== 0) begin errors++; $display("FAIL reset_refund: got v=%b a=%0d want 0/0", refund_valid, refund_amt); end
    checks++; if (coin_reject !== 1'b0 || sel_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got cr=%b se=%b want 0/0", coin_reject, sel_err); end
  endtask

  task automatic test_basic_purchase();
    pulse_coin(5);
    checks++; if (credit !== 5 || push !== P_CREDIT) begin errors++; $display("FAIL basic_coin1: got c=%0d p=%b want 5/%b", credit, push, P_CREDIT); end
    pulse_coin(5);
    checks++; if (credit !== 10) begin errors++; $display("FAIL basic_coin2: got %0d want 10", credit); end
    pulse_sel(1);
    checks++; if (dispense_valid !== 1'b1 || dispense_item !== 2'd1 || credit !== 3 || push !== P_DISP) begin
      errors++; $display("FAIL basic_sel: got v=%b i=%0d c=%0d p=%b want 1/1/3/%b", dispense_valid, dispense_item, credit, push, P_DISP); end
    dispense_ready = 1'b1; tick(); dispense_ready = 1'b0;
`ifdef VEND_MULTI_VEND_EN
    checks++; if (push !== P_CREDIT || credit !== 3 || dispense_valid !== 1'b0) begin errors++; $display("FAIL basic_after_disp: got p=%b c=%0d want %b/3", push, credit, P_CREDIT); end
    pulse_cancel();
`endif
    checks++; if (push !== P_REF || refund_valid !== 1'b1 || refund_amt !== 3 || dispense_valid !== 1'b0) begin
      errors++; $display("FAIL basic_refund: got p=%b v=%b a=%0d want %b/1/3", push, refund_valid, refund_amt, P_REF); end
    refund_ready = 1'b1; tick(); refund_ready = 1'b0;
    checks++; if (push !== P_IDLE || credit !== 0 || refund_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: got p=%b c=%0d v=%b want %b/0/0", push, credit, refund_valid, P_IDLE); end
  endtask

  task automatic test_sel_err();
    pulse_coin(4);
    pulse_sel(2);
    checks++; if (sel_err !== 1'b1 || credit !== 4 || push !== P_CREDIT) begin errors++; $display("FAIL selerr_short: got e=%b c=%0d p=%b want 1/4/%b", sel_err, credit, push, P_CREDIT); end
    tick();
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL selerr_pulse: got %b want 0", sel_err); end
    pulse_coin(6);
    pulse_sel(2);
    checks++; if (dispense_valid !== 1'b1 || dispense_item !== 2'd2 || credit !== 0) begin errors++; $display("FAIL selerr_exact: got v=%b i=%0d c=%0d want 1/2/0", dispense_valid, dispense_item, credit); end
    dispense_ready = 1'b1; tick(); dispense_ready = 1'b0;
    checks++; if (push !== P_IDLE || refund_valid !== 1'b0) begin errors++; $display("FAIL selerr_noref: got p=%b v=%b want %b/0", push, refund_valid, P_IDLE); end
  endtask

  task automatic test_stock_cancel();
    stock_empty = 4'b0100;
    pulse_coin(20);
    pulse_sel(2);
    checks++; if (sel_err !== 1'b1 || push !== P_CREDIT || credit !== 20) begin errors++; $display("FAIL stock_selerr: got e=%b p=%b c=%0d want 1/%b/20", sel_err, push, credit, P_CREDIT); end
    pulse_cancel();
    checks++; if (refund_valid !== 1'b1 || refund_amt !== 20 || push !== P_REF) begin errors++; $display("FAIL stock_cancel: got v=%b a=%0d p=%b want 1/20/%b", refund_valid, refund_amt, push, P_REF); end
    refund_ready = 1'b1; tick(); refund_ready = 1'b0;
    stock_empty = '0;
  endtask

  task automatic test_overflow_priority();
    pulse_coin(250);
    pulse_coin(10);
    checks++; if (coin_reject !== 1'b1 || credit !== 250) begin errors++; $display("FAIL ovf_reject: got r=%b c=%0d want 1/250", coin_reject, credit); end
    cancel = 1'b1; sel_valid = 1'b1; sel_item = 2'd0;
    tick();
    cancel = 1'b0; sel_valid = 1'b0;
    checks++; if (push !== P_REF || refund_amt !== 250 || dispense_valid !== 1'b0 || sel_err !== 1'b0) begin
      errors++; $display("FAIL cancel_over_sel: got p=%b a=%0d dv=%b e=%b want %b/250/0/0", push, refund_amt, dispense_valid, sel_err, P_REF); end
    refund_ready = 1'b1; tick(); refund_ready = 1'b0;
  endtask

  task automatic test_timeout_hold();
    int n;
    pulse_coin(3);
    n = 0;
    while (refund_valid !== 1'b1 && n < TO + 100) begin tick(); n++; end
    checks++; if (n !== TO) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (refund_valid !== 1'b1 || refund_amt !== 3 || push !== P_REF) begin errors++; $display("FAIL refund_hold%0d: got v=%b a=%0d want 1/3", k, refund_valid, refund_amt); end
    end
    refund_ready = 1'b1; tick(); refund_ready = 1'b0;
    checks++; if (push !== P_IDLE || credit !== 0) begin errors++; $display("FAIL timeout_done: got p=%b c=%0d want %b/0", push, credit, P_IDLE); end
  endtask

  task automatic test_zero_coin_cancel();
    pulse_coin(0);
    checks++; if (push !== P_CREDIT || credit !== 0) begin errors++; $display("FAIL zero_coin: got p=%b c=%0d want %b/0", push, credit, P_CREDIT); end
    pulse_cancel();
    checks++; if (push !== P_IDLE || refund_valid !== 1'b0) begin errors++; $display("FAIL zero_cancel: got p=%b v=%b want %b/0", push, refund_valid, P_IDLE); end
  endtask

  task automatic test_reset_in_dispense();
    pulse_coin(15);
    pulse_sel(3);
    checks++; if (dispense_valid !== 1'b1 || dispense_item !== 2'd3) begin errors++; $display("FAIL rst_pre: got v=%b i=%0d want 1/3", dispense_valid, dispense_item); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (dispense_valid !== 1'b0 || dispense_item !== 2'd0 || credit !== 0 || push !== P_IDLE || refund_valid !== 1'b0 || refund_amt !== 0) begin
      errors++; $display("FAIL rst_mid: got dv=%b di=%0d c=%0d p=%b rv=%b ra=%0d want all reset", dispense_valid, dispense_item, credit, push, refund_valid, refund_amt); end
  endtask

`ifdef VEND_MULTI_VEND_EN
  task automatic test_multi_vend();
    pulse_coin(20);
    pulse_sel(0);
    dispense_ready = 1'b1; tick(); dispense_ready = 1'b0;
    checks++; if (push !== P_CREDIT || credit !== 15) begin errors++; $display("FAIL multi_first: got p=%b c=%0d want %b/15", push, credit, P_CREDIT); end
    pulse_sel(0);
    checks++; if (dispense_valid !== 1'b1 || credit !== 10) begin errors++; $display("FAIL multi_second: got v=%b c=%0d want 1/10", dispense_valid, credit); end
    dispense_ready = 1'b1; tick(); dispense_ready = 1'b0;
    checks++; if (push !== P_CREDIT || credit !== 10 || refund_valid !== 1'b0) begin errors++; $display("FAIL multi_remain: got p=%b c=%0d want %b/10", push, credit, P_CREDIT); end
    pulse_cancel();
    refund_ready = 1'b1; tick(); refund_ready = 1'b0;
  endtask
`endif

  task automatic test_random();
    int mc, outcome, op, it, sel_it, cv, waits, c, exp_rej, exp_err;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) pr[i] = $urandom_range(1, 60);
      apply_prices();
      stock_empty = 4'($urandom_range(0, 15));
      mc = $urandom_range(0, 60);
      pulse_coin(mc);
      checks++; if (credit !== AW'(mc) || push !== P_CREDIT) begin errors++; $display("FAIL rnd_first t%0d: got c=%0d p=%b want %0d", t, credit, push, mc); end
      outcome = 0; sel_it = 0;
      for (int k = 0; k < 8 && outcome == 0; k++) begin
        op = $urandom_range(0, 3);
        it = $urandom_range(0, 3);
        cv = $urandom_range(0, 255);
        c = (op == 0) ? 1 : $urandom_range(0, 1);
        coin_in = c[0]; coin_value = AW'(cv);
        sel_valid = (op == 1); sel_item = 2'(it);
        cancel = (op == 3);
        exp_rej = 0; exp_err = 0;
        if (op == 3) begin
          exp_rej = c; outcome = (mc != 0) ? 2 : 3;
        end else if (op == 1 && !stock_empty[it] && mc >= pr[it]) begin
          exp_rej = c; mc = mc - pr[it]; sel_it = it; outcome = 1;
        end else begin
          exp_err = (op == 1) ? 1 : 0;
          if (c != 0) begin
            if (mc + cv > 255) exp_rej = 1;
            else mc = mc + cv;
          end
        end
        tick();
        coin_in = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
        checks++; if (credit !== AW'(mc) || push !== push_for(outcome) || coin_reject !== exp_rej[0] || sel_err !== exp_err[0]) begin
          errors++; $display("FAIL rnd_op t%0d k%0d op%0d: got c=%0d p=%b r=%b e=%b want %0d/%b/%0d/%0d", t, k, op, credit, push, coin_reject, sel_err, mc, push_for(outcome), exp_rej, exp_err); end
      end
      if (outcome == 0) begin
        pulse_cancel();
        outcome = (mc != 0) ? 2 : 3;
      end
      if (outcome == 1) begin
        checks++; if (dispense_valid !== 1'b1 || dispense_item !== 2'(sel_it)) begin errors++; $display("FAIL rnd_disp t%0d: got v=%b i=%0d want 1/%0d", t, dispense_valid, dispense_item, sel_it); end
        waits = $urandom_range(0, 3);
        for (int w = 0; w < waits; w++) begin
          c = $urandom_range(0, 1); coin_in = c[0]; coin_value = AW'($urandom_range(1, 255));
          tick(); coin_in = 1'b0;
          checks++; if (dispense_valid !== 1'b1 || dispense_item !== 2'(sel_it) || credit !== AW'(mc) || coin_reject !== c[0]) begin
            errors++; $display("FAIL rnd_disp_hold t%0d: got v=%b i=%0d c=%0d r=%b want 1/%0d/%0d/%0d", t, dispense_valid, dispense_item, credit, coin_reject, sel_it, mc, c); end
        end
        dispense_ready = 1'b1; tick(); dispense_ready = 1'b0;
        if (mc != 0) begin
`ifdef VEND_MULTI_VEND_EN
          checks++; if (push !== P_CREDIT || credit !== AW'(mc)) begin errors++; $display("FAIL rnd_multi t%0d: got p=%b c=%0d want %b/%0d", t, push, credit, P_CREDIT, mc); end
          pulse_cancel();
`endif
          outcome = 2;
        end else outcome = 3;
      end
      checks++; if (push !== push_for(outcome) || (outcome == 2 && (refund_valid !== 1'b1 || refund_amt !== AW'(mc)))) begin
        errors++; $display("FAIL rnd_end t%0d: got p=%b v=%b a=%0d want %b amt %0d", t, push, refund_valid, refund_amt, push_for(outcome), mc); end
      if (outcome == 2) begin
        waits = $urandom_range(0, 3);
        for (int w = 0; w < waits; w++) begin
          c = $urandom_range(0, 1); coin_in = c[0]; coin_value = AW'($urandom_range(1, 255));
          tick(); coin_in = 1'b0;
          checks++; if (refund_valid !== 1'b1 || refund_amt !== AW'(mc) || coin_reject !== c[0]) begin
            errors++; $display("FAIL rnd_ref_hold t%0d: got v=%b a=%0d r=%b want 1/%0d/%0d", t, refund_valid, refund_amt, coin_reject, mc, c); end
        end
        refund_ready = 1'b1; tick(); refund_ready = 1'b0;
      end
      checks++; if (push !== P_IDLE || credit !== 0 || refund_valid !== 1'b0 || dispense_valid !== 1'b0) begin
        errors++; $display("FAIL rnd_idle t%0d: got p=%b c=%0d rv=%b dv=%b want idle", t, push, credit, refund_valid, dispense_valid); end
    end
  endtask

  initial begin
    pr[0] = 5; pr[1] = 7; pr[2] = 10; pr[3] = 12;
    apply_prices();
    test_reset();
    test_basic_purchase();
    test_sel_err();
    test_stock_cancel();
    test_overflow_priority();
    test_timeout_hold();
    test_zero_coin_cancel();
    test_reset_in_dispense();
`ifdef VEND_MULTI_VEND_EN
    test_multi_vend();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
